phase_advance_accumulator: RTL and testbench

//  Sits directly downstream of the phase detector, one result per analysis frame.

---
 rtl/phase_advance_accumulator.sv | 152 +++++++++++++++
 tb/tb_phase_advance_accumulator.sv | 121 ++++++++++++
 2 files changed

// File: rtl/phase_advance_accumulator.sv
// Phase-vocoder phase advance: wrapped deviation -> true bin frequency -> pitch-scaled
// advance, accumulated into the synthesis phase. Four registered stages, no backpressure.
module phase_advance_accumulator #(
  parameter int ADDR_WIDTH   = 11,
  parameter int PHASE_WIDTH  = 24,
  parameter int OVERLAP_LOG2 = 2,
  parameter int RATIO_WIDTH  = 16,
  parameter int RATIO_FRAC   = 12,
  parameter int FREQ_FRAC    = 8,
  parameter int JUMP_TOL     = 1
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic [PHASE_WIDTH-1:0]                phase,
  input  logic [PHASE_WIDTH-1:0]                phase_last,
  input  logic                                  phases_valid,
  input  logic [ADDR_WIDTH-2:0]                 k_max,
  input  logic [RATIO_WIDTH-1:0]                ratio,
  output logic signed [ADDR_WIDTH+FREQ_FRAC:0]  freq,
  output logic [PHASE_WIDTH-1:0]                synth_phase,
  output logic [ADDR_WIDTH-2:0]                 shifted_bin,
  output logic                                  restart,
  output logic                                  out_valid
);
  localparam int STAGES = 4;
  localparam int PW  = PHASE_WIDTH;
  localparam int RW  = RATIO_WIDTH;
  localparam int KW  = ADDR_WIDTH - 1;
  localparam int FW  = ADDR_WIDTH + FREQ_FRAC + 1;
  localparam int SH  = PHASE_WIDTH - OVERLAP_LOG2;
  localparam int AVW = PHASE_WIDTH + ADDR_WIDTH;
  localparam int PRW = AVW + RW + 1;
  localparam int BPW = FW + RW + 1;
  localparam int BSH = RATIO_FRAC + FREQ_FRAC;
  localparam logic signed [BPW-1:0] RND     = BPW'(1) << (BSH - 1);
  localparam logic signed [BPW-1:0] BIN_MAX = BPW'((1 << KW) - 1);

  logic [STAGES:1] r_vld_pipe;

  // S1
  logic [PW-1:0] r1_diff, r1_phase;
  logic [KW-1:0] r1_k;
  logic [RW-1:0] r1_ratio;
  // S2
  logic signed [FW-1:0]  r2_freq;
  logic signed [AVW-1:0] r2_adv;
  logic [PW-1:0]         r2_phase;
  logic [RW-1:0]         r2_ratio;
  logic                  r2_jump;
  logic [KW-1:0]         r_k_prev;
  logic                  r_first;
  // S3
  logic signed [FW-1:0] r3_freq;
  logic [PW-1:0]        r3_padv, r3_phase;
  logic [KW-1:0]        r3_bin;
  logic                 r3_jump;

  logic [KW+SH-1:0]      w_exp_full;
  logic signed [PW-1:0]  w_dev;
  logic signed [FW-1:0]  w_freq;
  logic signed [AVW-1:0] w_adv;
  logic [KW-1:0]         w_kd;
  logic                  w_jump;
  logic signed [RW:0]    w_ratio_s;
  logic signed [PRW-1:0] w_prod;
  logic [PW-1:0]         w_padv;
  logic signed [BPW-1:0] w_bprod, w_bq;
  logic [KW-1:0]         w_bin;

  // Expected advance is k * 2^SH; only its low PW bits matter for the wrapped deviation,
  // but the full width is kept for the unwrapped advance.
  assign w_exp_full = {r1_k, {SH{1'b0}}};
  assign w_dev      = $signed(r1_diff - w_exp_full[PW-1:0]);
  assign w_freq     = $signed({{(FW-KW-FREQ_FRAC){1'b0}}, r1_k, {FREQ_FRAC{1'b0}}})
                    + FW'(w_dev >>> (SH - FREQ_FRAC));
  assign w_adv      = $signed({{(AVW-KW-SH){1'b0}}, w_exp_full}) + AVW'(w_dev);
  assign w_kd       = (r1_k >= r_k_prev) ? (r1_k - r_k_prev) : (r_k_prev - r1_k);
  assign w_jump     = r_first | (w_kd > KW'(JUMP_TOL));

  assign w_ratio_s  = $signed({1'b0, r2_ratio});
  assign w_prod     = PRW'(r2_adv) * PRW'(w_ratio_s);
  assign w_padv     = PW'(w_prod >>> RATIO_FRAC);
  assign w_bprod    = BPW'(r2_freq) * BPW'(w_ratio_s) + RND;
  assign w_bq       = w_bprod >>> BSH;

  always_comb begin
    w_bin = w_bq[KW-1:0];
    if (w_bq[BPW-1])        w_bin = '0;
    else if (w_bq > BIN_MAX) w_bin = '1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_pipe  <= '0;
      r1_diff     <= '0;
      r1_phase    <= '0;
      r1_k        <= '0;
      r1_ratio    <= '0;
      r2_freq     <= '0;
      r2_adv      <= '0;
      r2_phase    <= '0;
      r2_ratio    <= '0;
      r2_jump     <= 1'b0;
      r_k_prev    <= '0;
      r_first     <= 1'b1;
      r3_freq     <= '0;
      r3_padv     <= '0;
      r3_phase    <= '0;
      r3_bin      <= '0;
      r3_jump     <= 1'b0;
      freq        <= '0;
      synth_phase <= '0;
      shifted_bin <= '0;
      restart     <= 1'b0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], phases_valid};
      if (phases_valid) begin
        r1_diff  <= phase - phase_last;
        r1_phase <= phase;
        r1_k     <= k_max;
        r1_ratio <= ratio;
      end
      // first_frame is consumed where the jump decision is made so back-to-back
      // frames following the first one compare against a real k_prev.
      if (r_vld_pipe[1]) begin
        r2_freq  <= w_freq;
        r2_adv   <= w_adv;
        r2_phase <= r1_phase;
        r2_ratio <= r1_ratio;
        r2_jump  <= w_jump;
        r_k_prev <= r1_k;
        r_first  <= 1'b0;
      end
      if (r_vld_pipe[2]) begin
        r3_freq  <= r2_freq;
        r3_padv  <= w_padv;
        r3_phase <= r2_phase;
        r3_bin   <= w_bin;
        r3_jump  <= r2_jump;
      end
      if (r_vld_pipe[3]) begin
        freq        <= r3_freq;
        shifted_bin <= r3_bin;
        restart     <= r3_jump;
        synth_phase <= r3_jump ? r3_phase : synth_phase + r3_padv;
      end
    end
  end

  assign out_valid = r_vld_pipe[STAGES];

endmodule

// File: tb/tb_phase_advance_accumulator.sv
// Directed-vector bench for phase_advance_accumulator; expected values hand-computed.
module tb_phase_advance_accumulator;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [23:0] phase, phase_last;
  logic        phases_valid;
  logic [9:0]  k_max;
  logic [15:0] ratio;
  logic [19:0] freq;
  logic [23:0] synth_phase;
  logic [9:0]  shifted_bin;
  logic        restart, out_valid;

  int n_tot = 0;
  int n_bad = 0;

  phase_advance_accumulator dut (
    .clock(clock), .reset_n(reset_n), .phase(phase), .phase_last(phase_last),
    .phases_valid(phases_valid), .k_max(k_max), .ratio(ratio), .freq(freq),
    .synth_phase(synth_phase), .shifted_bin(shifted_bin), .restart(restart),
    .out_valid(out_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [19:0] ef, input logic [23:0] es,
                           input logic [9:0] eb, input logic er);
    chk({tag, "_vld"},   32'(out_valid),   32'd1);
    chk({tag, "_freq"},  32'(freq),        32'(ef));
    chk({tag, "_synth"}, 32'(synth_phase), 32'(es));
    chk({tag, "_bin"},   32'(shifted_bin), 32'(eb));
    chk({tag, "_rst"},   32'(restart),     32'(er));
  endtask

  task automatic drive(input logic [23:0] ph, input logic [23:0] pl, input logic [9:0] k,
                       input logic [15:0] r);
    phase = ph; phase_last = pl; k_max = k; ratio = r; phases_valid = 1'b1;
  endtask

  task automatic run_frame(input string tag, input logic [23:0] ph, input logic [23:0] pl,
                           input logic [9:0] k, input logic [15:0] r, input logic [19:0] ef,
                           input logic [23:0] es, input logic [9:0] eb, input logic er);
    int lat;
    lat = 0;
    @(negedge clock);
    drive(ph, pl, k, r);
    do begin
      @(posedge clock); #1;
      phases_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 10);
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    check_out(tag, ef, es, eb, er);
  endtask

  initial begin
    int highs;
    reset_n = 1'b0; phases_valid = 1'b0;
    phase = '0; phase_last = '0; k_max = '0; ratio = '0;
    #12;
    chk("rst_vld",   32'(out_valid),   32'd0);
    chk("rst_freq",  32'(freq),        32'd0);
    chk("rst_synth", 32'(synth_phase), 32'd0);
    chk("rst_bin",   32'(shifted_bin), 32'd0);
    chk("rst_rst",   32'(restart),     32'd0);
    @(negedge clock); reset_n = 1'b1;

    //        tag       phase      last       k     ratio     freq       synth      bin  rst
    run_frame("first",  24'h123456, 24'h0,     10'd10, 16'h1000, 20'h00848, 24'h123456, 10'd8,  1'b1);
    run_frame("pi",     24'h800000, 24'h0,     10'd10, 16'h1000, 20'h00A00, 24'h923456, 10'd10, 1'b0);
    run_frame("devpos", 24'h810000, 24'h0,     10'd10, 16'h1000, 20'h00A04, 24'h133456, 10'd10, 1'b0);
    run_frame("wrapp",  24'h810000, 24'h7F0000, 10'd0, 16'h1000, 20'h00008, 24'h810000, 10'd0,  1'b1);
    run_frame("wrapn",  24'h7F0000, 24'h810000, 10'd0, 16'h1000, 20'hFFFF8, 24'h7F0000, 10'd0,  1'b0);
    run_frame("negpi",  24'h800000, 24'h0,     10'd0,  16'h1000, 20'hFFE00, 24'hFF0000, 10'd0,  1'b0);
    run_frame("ratio0", 24'h100000, 24'h0,     10'd0,  16'h0000, 20'h00040, 24'hFF0000, 10'd0,  1'b0);
    run_frame("s5a",    24'h200000, 24'h0,     10'd10, 16'h1000, 20'h00880, 24'h200000, 10'd9,  1'b1);
    run_frame("s5b",    24'h800000, 24'h0,     10'd10, 16'h1800, 20'h00A00, 24'hE00000, 10'd15, 1'b0);
    run_frame("s5jump", 24'h345678, 24'h0,     10'd13, 16'h1000, 20'h00CD1, 24'h345678, 10'd13, 1'b1);
    run_frame("sat",    24'h000000, 24'h0,     10'd1000, 16'h2000, 20'h3E800, 24'h000000, 10'd1023, 1'b1);

    // three frames back-to-back
    @(negedge clock); drive(24'h400000, 24'h0, 10'd1001, 16'h1000);
    @(negedge clock); drive(24'h800000, 24'h0, 10'd1002, 16'h1000);
    @(negedge clock); drive(24'h000000, 24'h0, 10'd1000, 16'h1000);
    @(negedge clock); phases_valid = 1'b0;
    @(posedge clock); #1;
    check_out("b2b0", 20'h3E900, 24'h400000, 10'd1001, 1'b0);
    @(posedge clock); #1;
    check_out("b2b1", 20'h3EA00, 24'hC00000, 10'd1002, 1'b0);
    @(posedge clock); #1;
    check_out("b2b2", 20'h3E800, 24'h000000, 10'd1000, 1'b1);
    @(posedge clock); #1;
    chk("b2b_end", 32'(out_valid), 32'd0);

    // reset with a frame in flight
    @(negedge clock); drive(24'h222222, 24'h0, 10'd1000, 16'h1000);
    @(negedge clock); phases_valid = 1'b0;
    @(negedge clock); reset_n = 1'b0;
    #1;
    chk("midrst_synth", 32'(synth_phase), 32'd0);
    @(negedge clock); @(negedge clock); reset_n = 1'b1;
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      if (out_valid) highs++;
    end
    chk("midrst_novld", 32'(highs), 32'd0);
    run_frame("postrst", 24'h111111, 24'h111111, 10'd1000, 16'h1000, 20'h3E800, 24'h111111, 10'd1000, 1'b1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
